// File: rtl/intt_half_scaler_pkg.sv
// Shared constants and types for the INTT N^-1 scaler: moduli, FSM encoding, modulus select.
// The optional range check is built only when HALF_SCALER_RANGE_CHK_EN is defined.
package intt_half_scaler_pkg;

  localparam logic [63:0] Q0 = 64'd274877382657;
  localparam logic [63:0] Q1 = 64'd274877120513;
  localparam logic [63:0] Q2 = 64'd274876858369;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_HALVE = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  function automatic logic [63:0] q_of(input int q_type);
    case (q_type)
      1:       q_of = Q1;
      2:       q_of = Q2;
      default: q_of = Q0;
    endcase
  endfunction

endpackage

// File: rtl/intt_half_scaler_if.sv
// Control and coefficient-RAM bus of the scaler; o_range_err exists only with HALF_SCALER_RANGE_CHK_EN.
// Handshake: i_start is accepted only while the scaler is idle (o_busy low, o_done low);
// i_rd_data must be valid exactly one cycle after o_rd_en; o_wr_* is a single-cycle write strobe.
interface intt_half_scaler_if #(
  parameter int COE_WIDTH   = 39,
  parameter int ADDR_WIDTH  = 10,
  parameter int SHIFT_WIDTH = 4
);
  logic                   i_start;
  logic [SHIFT_WIDTH-1:0] i_shift;
  logic [ADDR_WIDTH:0]    i_len;
  logic                   o_busy;
  logic                   o_done;
  logic                   o_rd_en;
  logic [ADDR_WIDTH-1:0]  o_rd_addr;
  logic [COE_WIDTH-1:0]   i_rd_data;
  logic                   o_wr_en;
  logic [ADDR_WIDTH-1:0]  o_wr_addr;
  logic [COE_WIDTH-1:0]   o_wr_data;
`ifdef HALF_SCALER_RANGE_CHK_EN
  logic                   o_range_err;
`endif

  modport slave (
    input  i_start, i_shift, i_len, i_rd_data,
    output o_busy, o_done, o_rd_en, o_rd_addr, o_wr_en, o_wr_addr, o_wr_data
`ifdef HALF_SCALER_RANGE_CHK_EN
    , output o_range_err
`endif
  );

  modport master (
    output i_start, i_shift, i_len, i_rd_data,
    input  o_busy, o_done, o_rd_en, o_rd_addr, o_wr_en, o_wr_addr, o_wr_data
`ifdef HALF_SCALER_RANGE_CHK_EN
    , input o_range_err
`endif
  );

endinterface

// File: rtl/intt_half_scaler_halfred.sv
// Combinational modular halving: returns x * 2^-1 mod Q for x < Q, without carry out.
module intt_half_scaler_halfred
  import intt_half_scaler_pkg::*;
#(
  parameter int COE_WIDTH = 39,
  parameter int Q_TYPE    = 0
) (
  input  logic [COE_WIDTH-1:0] i_x,
  output logic [COE_WIDTH-1:0] o_y
);

  localparam logic [COE_WIDTH-1:0] Q = COE_WIDTH'(q_of(Q_TYPE));
  // Q is odd, so (Q+1)/2 == (Q>>1)+1 and never overflows the width.
  localparam logic [COE_WIDTH-1:0] HALF_Q = (Q >> 1) + COE_WIDTH'(1);

  logic [COE_WIDTH-1:0] w_shr;

  assign w_shr = {1'b0, i_x[COE_WIDTH-1:1]};
  assign o_y   = w_shr + (i_x[0] ? HALF_Q : '0);

endmodule

// File: rtl/intt_half_scaler.sv
// In-place batch scaler: multiplies RAM coefficients by (1/2)^shift mod Q, one halving per cycle.
// Defining HALF_SCALER_RANGE_CHK_EN adds a sticky o_range_err flag for loaded values >= Q.
module intt_half_scaler
  import intt_half_scaler_pkg::*;
#(
  parameter int COE_WIDTH   = 39,
  parameter int Q_TYPE      = 0,
  parameter int ADDR_WIDTH  = 10,
  parameter int SHIFT_WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  intt_half_scaler_if.slave   bus,
  output state_t              o_dbg_state
);

  state_t                 r_state;
  state_t                 w_next;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [ADDR_WIDTH:0]    r_len;
  logic [SHIFT_WIDTH-1:0] r_shift;
  logic [SHIFT_WIDTH-1:0] r_cnt;
  logic [COE_WIDTH-1:0]   r_work;
  logic [COE_WIDTH-1:0]   w_half;
  logic                   w_last;

  intt_half_scaler_halfred #(
    .COE_WIDTH (COE_WIDTH),
    .Q_TYPE    (Q_TYPE)
  ) u_halfred (
    .i_x (r_work),
    .o_y (w_half)
  );

  assign w_last = ({1'b0, r_addr} == (r_len - (ADDR_WIDTH+1)'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_len   <= '0;
      r_shift <= '0;
      r_cnt   <= '0;
      r_work  <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          if (bus.i_start) begin
            r_shift <= bus.i_shift;
            r_len   <= bus.i_len;
            r_addr  <= '0;
          end
        end
        ST_LOAD: begin
          r_work <= bus.i_rd_data;
          r_cnt  <= r_shift;
        end
        ST_HALVE: begin
          r_work <= w_half;
          r_cnt  <= r_cnt - SHIFT_WIDTH'(1);
        end
        ST_WRITE: begin
          if (!w_last) r_addr <= r_addr + ADDR_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (bus.i_start) w_next = (bus.i_len == '0) ? ST_DONE : ST_READ;
      ST_READ:  w_next = ST_LOAD;
      ST_LOAD:  w_next = (r_shift != '0) ? ST_HALVE : ST_WRITE;
      ST_HALVE: if (r_cnt == SHIFT_WIDTH'(1)) w_next = ST_WRITE;
      ST_WRITE: w_next = w_last ? ST_DONE : ST_READ;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Moore outputs; address/data are forced to zero outside their strobe.
  assign bus.o_busy    = (r_state == ST_READ) || (r_state == ST_LOAD) ||
                         (r_state == ST_HALVE) || (r_state == ST_WRITE);
  assign bus.o_done    = (r_state == ST_DONE);
  assign bus.o_rd_en   = (r_state == ST_READ);
  assign bus.o_rd_addr = (r_state == ST_READ) ? r_addr : '0;
  assign bus.o_wr_en   = (r_state == ST_WRITE);
  assign bus.o_wr_addr = (r_state == ST_WRITE) ? r_addr : '0;
  assign bus.o_wr_data = (r_state == ST_WRITE) ? r_work : '0;
  assign o_dbg_state   = r_state;

`ifdef HALF_SCALER_RANGE_CHK_EN
  localparam logic [COE_WIDTH-1:0] Q = COE_WIDTH'(q_of(Q_TYPE));
  logic r_range_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_range_err <= 1'b0;
    end else if ((r_state == ST_IDLE) && bus.i_start) begin
      r_range_err <= 1'b0;
    end else if ((r_state == ST_LOAD) && (bus.i_rd_data >= Q)) begin
      r_range_err <= 1'b1;
    end
  end

  assign bus.o_range_err = r_range_err;
`endif

endmodule
